// File: rtl/payload_buffer_scheduler.sv
// rtl/payload_buffer_scheduler.sv - payload linked-list buffer access scheduler
module payload_buffer_scheduler #(
   parameter int NUM_READERS = 4,
   parameter int ADDR_W      = 12,
   parameter int NUM_BLOCKS  = 4096,
   parameter int MAX_BLOCKS  = 64,
   localparam int SEL_W      = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_req,
   input  logic                          wr_valid,
   input  logic                          wr_last,
   output logic                          wr_ready,
   output logic [ADDR_W-1:0]             wr_head,
   output logic                          wr_head_valid,
   input  logic [NUM_READERS-1:0]        rd_req,
   input  logic [NUM_READERS*ADDR_W-1:0] rd_head,
   output logic [NUM_READERS-1:0]        rd_grant,
   output logic [SEL_W-1:0]              rd_sel,
   output logic                          rd_valid,
   output logic                          rd_last,
   output logic                          err_chain,
   output logic [ADDR_W:0]               free_count,
   output logic                          buf_enable,
   output logic                          buf_read_write,
   output logic                          buf_rd_is_first,
   output logic [ADDR_W-1:0]             buf_rd_address,
   input  logic                          buf_rd_is_last,
   input  logic                          buf_rd_ttl_zero,
   input  logic [ADDR_W-1:0]             buf_wr_address
);

   localparam int CNT_W = $clog2(MAX_BLOCKS) + 1;
   localparam logic [ADDR_W:0]  FREE_MAX = (ADDR_W+1)'(NUM_BLOCKS);
   localparam logic [ADDR_W:0]  WR_MIN   = (ADDR_W+1)'(MAX_BLOCKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BLOCKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WR_DONE,
      S_RD_FIRST,
      S_RD_WALK
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SEL_W-1:0]   rr_ptr;
   logic [SEL_W-1:0]   rr_pick;
   logic [SEL_W-1:0]   cand;
   logic [ADDR_W-1:0]  head_sel;
   logic [CNT_W-1:0]   blk_cnt;
   logic               last_write;
   logic               wr_elig;
   logic               rd_elig;
   logic               grant_wr;
   logic               grant_rd;
   logic               walk_done;
   logic               wr_accept;
   logic               rd_free;

   assign wr_elig   = wr_req && (free_count >= WR_MIN);
   assign rd_elig   = |rd_req;
   assign wr_accept = (state == S_WRITE) && wr_valid;
   assign rd_free   = (state == S_RD_WALK) && buf_rd_ttl_zero;

   // Round-robin search: the requester closest after rr_ptr (inclusive) wins.
   always_comb begin
      rr_pick = '0;
      cand    = '0;
      for (int i = NUM_READERS - 1; i >= 0; i--) begin
         cand = SEL_W'((int'(rr_ptr) + i) % NUM_READERS);
         if (rd_req[cand]) begin
            rr_pick = cand;
         end
      end
   end

   // Chain head of the reader owning the current walk.
   always_comb begin
      head_sel = '0;
      for (int i = 0; i < NUM_READERS; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            head_sel = rd_head[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and buffer/port controls.
   always_comb begin
      state_nxt       = state;
      grant_wr        = 1'b0;
      grant_rd        = 1'b0;
      walk_done       = 1'b0;
      wr_ready        = 1'b0;
      wr_head         = '0;
      wr_head_valid   = 1'b0;
      rd_grant        = '0;
      rd_valid        = 1'b0;
      rd_last         = 1'b0;
      err_chain       = 1'b0;
      buf_enable      = 1'b0;
      buf_read_write  = 1'b0;
      buf_rd_is_first = 1'b0;
      buf_rd_address  = '0;
      case (state)
         S_IDLE: begin
            // On contention, serve the class that did not go last.
            grant_wr = wr_elig && (!rd_elig || !last_write);
            grant_rd = rd_elig && !grant_wr;
            if (grant_wr) begin
               state_nxt = S_WRITE;
            end else if (grant_rd) begin
               state_nxt = S_RD_FIRST;
            end
         end
         S_WRITE: begin
            wr_ready       = 1'b1;
            buf_read_write = 1'b1;
            buf_enable     = wr_valid;
            if (wr_valid && wr_last) begin
               state_nxt = S_WR_DONE;
            end
         end
         S_WR_DONE: begin
            wr_head       = buf_wr_address;
            wr_head_valid = 1'b1;
            state_nxt     = S_IDLE;
         end
         S_RD_FIRST: begin
            buf_enable       = 1'b1;
            buf_rd_is_first  = 1'b1;
            buf_rd_address   = head_sel;
            rd_grant[rd_sel] = 1'b1;
            state_nxt        = S_RD_WALK;
         end
         S_RD_WALK: begin
            // Enable stays high on the last block so the TTL writeback lands.
            buf_enable = 1'b1;
            rd_valid   = 1'b1;
            rd_last    = buf_rd_is_last;
            if (buf_rd_is_last) begin
               walk_done = 1'b1;
               state_nxt = S_IDLE;
            end else if (blk_cnt == CNT_LAST) begin
               err_chain = 1'b1;
               walk_done = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Reader selection, fairness pointers, walk watchdog and free-block accounting.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_sel     <= '0;
         rr_ptr     <= '0;
         last_write <= 1'b0;
         blk_cnt    <= '0;
         free_count <= FREE_MAX;
      end else begin
         if (grant_rd) begin
            rd_sel <= rr_pick;
         end
         if (state == S_RD_FIRST) begin
            blk_cnt <= '0;
            rr_ptr  <= (rd_sel == SEL_W'(NUM_READERS - 1)) ? '0 : rd_sel + 1'b1;
         end else if (state == S_RD_WALK) begin
            blk_cnt <= blk_cnt + 1'b1;
         end
         if (state == S_WR_DONE) begin
            last_write <= 1'b1;
         end else if (walk_done) begin
            last_write <= 1'b0;
         end
         if (wr_accept) begin
            if (free_count != '0) begin
               free_count <= free_count - 1'b1;
            end
         end else if (rd_free) begin
            if (free_count != FREE_MAX) begin
               free_count <= free_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_payload_buffer_scheduler.sv
// tb/tb_payload_buffer_scheduler.sv - randomized self-checking bench for payload_buffer_scheduler
module tb_payload_buffer_scheduler;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int NB = 4096;
   localparam int MB = 64;

   logic            clock = 1'b0;
   logic            reset;
   logic            wr_req;
   logic            wr_valid;
   logic            wr_last;
   logic            wr_ready;
   logic [AW-1:0]   wr_head;
   logic            wr_head_valid;
   logic [N-1:0]    rd_req;
   logic [N*AW-1:0] rd_head;
   logic [N-1:0]    rd_grant;
   logic [1:0]      rd_sel;
   logic            rd_valid;
   logic            rd_last;
   logic            err_chain;
   logic [AW:0]     free_count;
   logic            buf_enable;
   logic            buf_read_write;
   logic            buf_rd_is_first;
   logic [AW-1:0]   buf_rd_address;
   logic            buf_rd_is_last;
   logic            buf_rd_ttl_zero;
   logic [AW-1:0]   buf_wr_address;

   int checks = 0;
   int errors = 0;

   // reference model: free blocks, next round-robin start, last served class
   int m_free;
   int m_rr;
   bit m_last_write;

   payload_buffer_scheduler dut (
      .clock(clock), .reset(reset),
      .wr_req(wr_req), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
      .wr_head(wr_head), .wr_head_valid(wr_head_valid),
      .rd_req(rd_req), .rd_head(rd_head), .rd_grant(rd_grant), .rd_sel(rd_sel),
      .rd_valid(rd_valid), .rd_last(rd_last), .err_chain(err_chain), .free_count(free_count),
      .buf_enable(buf_enable), .buf_read_write(buf_read_write), .buf_rd_is_first(buf_rd_is_first),
      .buf_rd_address(buf_rd_address), .buf_rd_is_last(buf_rd_is_last),
      .buf_rd_ttl_zero(buf_rd_ttl_zero), .buf_wr_address(buf_wr_address)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; wr_req = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      rd_req = '0; rd_head = '0; buf_rd_is_last = 1'b0; buf_rd_ttl_zero = 1'b0;
      buf_wr_address = '0;
      tick; tick;
      reset = 1'b0;
      m_free = NB; m_rr = 0; m_last_write = 1'b0;
   endtask

   task automatic write_packet(input int nblk, input logic [AW-1:0] addr, input bit stalls,
                               output int ready_cycles);
      int cyc;
      int sent;
      bit seen_rd;
      cyc = 0; sent = 0; seen_rd = 0; ready_cycles = 0;
      wr_req = 1'b1;
      #1;
      while (wr_ready !== 1'b1 && cyc < 20) begin
         if (rd_grant !== '0) seen_rd = 1;
         tick; #1; cyc++;
      end
      checks++;
      if (cyc >= 20) begin
         errors++; $display("FAIL wr_grant_timeout: wr_ready=%b expected 1", wr_ready);
         wr_req = 1'b0;
         return;
      end
      checks++;
      if (seen_rd) begin
         errors++; $display("FAIL wr_arbitration: read granted=1 expected 0");
      end
      wr_req = 1'b0;
      while (sent < nblk && cyc < 1000) begin
         wr_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
         wr_last = wr_valid && (sent == nblk - 1);
         buf_wr_address = addr;
         #1;
         checks++;
         if (wr_ready !== 1'b1 || buf_read_write !== 1'b1 || buf_enable !== wr_valid) begin
            errors++;
            $display("FAIL write_ctl: ready/rw/en=%b%b%b expected 11%b",
                     wr_ready, buf_read_write, buf_enable, wr_valid);
         end
         if (wr_ready === 1'b1) ready_cycles++;
         if (wr_valid) sent++;
         tick; cyc++;
      end
      wr_valid = 1'b0; wr_last = 1'b0;
      #1;
      m_free = (m_free > nblk) ? m_free - nblk : 0;
      m_last_write = 1'b1;
      checks++;
      if (wr_head_valid !== 1'b1 || wr_head !== addr) begin
         errors++;
         $display("FAIL wr_head: valid=%b head=%h expected 1 %h", wr_head_valid, wr_head, addr);
      end
      checks++;
      if (free_count !== m_free) begin
         errors++; $display("FAIL free_after_write: got %0d expected %0d", free_count, m_free);
      end
      tick;
   endtask

   // nblk==0 models a chain that never returns isLast
   task automatic read_walk(input logic [N-1:0] mask, input int nblk, input int ttl_mode,
                            output int granted);
      int exp;
      int cyc;
      int limit;
      bit seen_wr;
      exp = -1; cyc = 0; seen_wr = 0; granted = -1;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            rd_req[i] = 1'b1;
            rd_head[i*AW +: AW] = AW'($urandom);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (exp < 0 && rd_req[(m_rr + i) % N]) exp = (m_rr + i) % N;
      end
      #1;
      while (rd_grant === '0 && cyc < 20) begin
         if (wr_ready === 1'b1) seen_wr = 1;
         tick; #1; cyc++;
      end
      checks++;
      if (cyc >= 20 || exp < 0) begin
         errors++; $display("FAIL rd_grant_timeout: rd_grant=%b expected one-hot", rd_grant);
         rd_req = '0;
         return;
      end
      for (int i = 0; i < N; i++) if (rd_grant[i]) granted = i;
      checks++;
      if (seen_wr) begin
         errors++; $display("FAIL rd_arbitration: write granted=1 expected 0");
      end
      checks++;
      if (rd_grant !== (N'(1) << exp) || rd_sel !== exp[1:0]) begin
         errors++;
         $display("FAIL rd_grant: grant=%b sel=%0d expected reader %0d", rd_grant, rd_sel, exp);
      end
      checks++;
      if (buf_rd_is_first !== 1'b1 || buf_enable !== 1'b1 || buf_read_write !== 1'b0 ||
          buf_rd_address !== rd_head[exp*AW +: AW]) begin
         errors++;
         $display("FAIL rd_first: first/en/rw=%b%b%b addr=%h expected 110 %h",
                  buf_rd_is_first, buf_enable, buf_read_write, buf_rd_address, rd_head[exp*AW +: AW]);
      end
      rd_req[exp] = 1'b0;
      tick;
      limit = (nblk == 0) ? MB : nblk;
      for (int k = 0; k < limit; k++) begin
         buf_rd_is_last = (nblk != 0) && (k == nblk - 1);
         buf_rd_ttl_zero = (ttl_mode == 1) ? 1'b1 : (ttl_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         checks++;
         if (rd_valid !== 1'b1 || rd_last !== buf_rd_is_last || rd_grant !== '0 ||
             buf_rd_is_first !== 1'b0 || buf_enable !== 1'b1 ||
             err_chain !== ((nblk == 0) && (k == MB - 1))) begin
            errors++;
            $display("FAIL rd_walk[%0d]: valid/last/first/en/err=%b%b%b%b%b expected 1%b01%b", k,
                     rd_valid, rd_last, buf_rd_is_first, buf_enable, err_chain,
                     buf_rd_is_last, (nblk == 0) && (k == MB - 1));
         end
         if (buf_rd_ttl_zero && m_free < NB) m_free++;
         tick;
      end
      buf_rd_is_last = 1'b0; buf_rd_ttl_zero = 1'b0;
      #1;
      checks++;
      if (rd_valid !== 1'b0 || err_chain !== 1'b0) begin
         errors++; $display("FAIL rd_end: valid/err=%b%b expected 00", rd_valid, err_chain);
      end
      checks++;
      if (free_count !== m_free) begin
         errors++; $display("FAIL free_after_read: got %0d expected %0d", free_count, m_free);
      end
      m_rr = (exp + 1) % N;
      m_last_write = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      #1;
      checks++;
      if ({wr_ready, wr_head_valid, wr_head, rd_grant, rd_sel, rd_valid, rd_last, err_chain,
           buf_enable, buf_read_write, buf_rd_is_first, buf_rd_address} !== '0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero, expected all 0");
      end
      checks++;
      if (free_count !== NB) begin
         errors++; $display("FAIL reset_free: got %0d expected %0d", free_count, NB);
      end
      tick;
   endtask

   task automatic test_write_basic;
      int rc;
      write_packet(3, 12'h005, 1'b0, rc);
      checks++;
      if (rc != 3) begin
         errors++; $display("FAIL wr_ready_cycles: got %0d expected 3", rc);
      end
      checks++;
      if (free_count !== 4093) begin
         errors++; $display("FAIL free_4093: got %0d expected 4093", free_count);
      end
   endtask

   task automatic test_read_basic;
      int g;
      rd_head[2*AW +: AW] = 12'h005;
      rd_req[2] = 1'b1;
      read_walk('0, 3, 2, g);
      checks++;
      if (g != 2) begin
         errors++; $display("FAIL read_basic_reader: got %0d expected 2", g);
      end
   endtask

   task automatic test_free_saturation;
      int g;
      do_reset;
      read_walk(4'b0100, 3, 1, g);
      checks++;
      if (free_count !== NB) begin
         errors++; $display("FAIL free_saturate: got %0d expected %0d", free_count, NB);
      end
   endtask

   task automatic test_round_robin;
      int g;
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset;
      for (int i = 0; i < 5; i++) begin
         read_walk(4'b1111, $urandom_range(1, 4), 2, g);
         checks++;
         if (g != order[i]) begin
            errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, g, order[i]);
         end
      end
   endtask

   task automatic test_arbitration;
      int rc;
      int g;
      do_reset;
      rd_req[1] = 1'b1;
      write_packet($urandom_range(1, 5), AW'($urandom), 1'b1, rc);
      wr_req = 1'b1;
      read_walk(4'b1000, $urandom_range(1, 4), 2, g);
      checks++;
      if (g != 1) begin
         errors++; $display("FAIL arb_read_after_write: got %0d expected 1", g);
      end
      write_packet($urandom_range(1, 5), AW'($urandom), 1'b1, rc);
      read_walk('0, $urandom_range(1, 4), 2, g);
      checks++;
      if (g != 3) begin
         errors++; $display("FAIL arb_second_read: got %0d expected 3", g);
      end
   endtask

   task automatic test_watchdog;
      int g;
      do_reset;
      read_walk(4'b0001, 0, 0, g);
   endtask

   task automatic test_admission;
      int rc;
      int g;
      do_reset;
      for (int p = 0; p < 63; p++) write_packet(MB, AW'($urandom), 1'b0, rc);
      write_packet(1, AW'($urandom), 1'b0, rc);
      checks++;
      if (free_count !== 63) begin
         errors++; $display("FAIL free_63: got %0d expected 63", free_count);
      end
      wr_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL admission_block: wr_ready=%b expected 0", wr_ready);
         end
         tick;
      end
      read_walk(4'b0001, 2, 1, g);
      write_packet(3, AW'($urandom), 1'b1, rc);
   endtask

   task automatic test_random;
      int rc;
      int g;
      do_reset;
      for (int it = 0; it < 12; it++) begin
         if (rd_req != '0 || $urandom_range(0, 1) == 1) begin
            read_walk((rd_req != '0) ? N'(0) : N'($urandom_range(1, 15)),
                      $urandom_range(1, 6), 2, g);
         end else begin
            write_packet($urandom_range(1, 8), AW'($urandom), 1'b1, rc);
         end
      end
      for (int d = 0; d < N && rd_req != '0; d++) read_walk('0, $urandom_range(1, 3), 2, g);
   endtask

   task automatic test_reset_mid;
      do_reset;
      wr_req = 1'b1;
      tick;
      wr_valid = 1'b1;
      tick; tick;
      reset = 1'b1;
      tick;
      reset = 1'b0; wr_valid = 1'b0; wr_req = 1'b0;
      #1;
      checks++;
      if (wr_ready !== 1'b0 || free_count !== NB) begin
         errors++;
         $display("FAIL reset_mid: wr_ready=%b free=%0d expected 0 %0d", wr_ready, free_count, NB);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_write_basic;
      test_read_basic;
      test_free_saturation;
      test_round_robin;
      test_arbitration;
      test_watchdog;
      test_admission;
      test_random;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
